mux_scan_serializer: RTL and testbench

Parallel-to-serial front end for the 8:1 mux datapath. Accepts an 8-bit word over a valid/ready handshake, holds it on the mux data inputs, and steps the mux select lines through all eight positions. It registers the mux output each step, producing a framed serial bit stream with downstream back-pressure. The 8:1 mux sits between this block's `mux_i`/`s0..s2` outputs and its `mux_y` input; the mux stays purely combinational.

---
 rtl/mux_scan_serializer.sv | 114 +++++++++++
 tb/tb_mux_scan_serializer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial front end for an external combinational 8:1 mux: holds a word on the mux
// inputs, walks the selects through all eight positions and registers the mux output per step.
module mux_scan_serializer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] mux_i,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    input  logic       mux_y,
    output logic       sout,
    output logic       sout_valid,
    input  logic       sout_ready,
    output logic       sout_first,
    output logic       sout_last,
    output logic       busy
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] hold_q, hold_d;
    logic       sout_q, sout_d;
    logic       valid_q, valid_d;
    logic       first_q, first_d;
    logic       last_q, last_d;

    logic [2:0] sel;
    logic       adv;
    logic       accept;

    // Selects come straight from the step counter so the mux settles within the cycle.
    assign sel = MSB_FIRST ? (3'd7 - cnt_q) : cnt_q;
    assign {s2, s1, s0} = sel;
    assign mux_i = hold_q;

    assign adv       = !valid_q || sout_ready;
    assign din_ready = !rst && ((state_q == StIdle) ||
                                ((state_q == StScan) && (cnt_q == 3'd7) && adv));
    assign accept    = din_valid && din_ready;

    assign sout       = sout_q;
    assign sout_valid = valid_q;
    assign sout_first = first_q;
    assign sout_last  = last_q;
    assign busy       = (state_q == StScan);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        sout_d  = sout_q;
        valid_d = valid_q;
        first_d = first_q;
        last_d  = last_q;

        unique case (state_q)
            StIdle: begin
                if (valid_q && sout_ready) begin
                    valid_d = 1'b0;
                    first_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            StScan: begin
                if (adv) begin
                    sout_d  = mux_y;
                    valid_d = 1'b1;
                    first_d = (cnt_q == 3'd0);
                    last_d  = (cnt_q == 3'd7);
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A new word may load on the same edge that captures the last bit of the previous one.
        if (accept) begin
            hold_d  = din;
            cnt_d   = 3'd0;
            state_d = StScan;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            hold_q  <= 8'h00;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Bench for mux_scan_serializer: LSB-first and MSB-first instances share stimulus; a negedge
// monitor checks every consumed bit against per-instance queues of expected {bit, first, last}.
module tb_mux_scan_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       sout_ready;

    logic       din_ready0, din_ready1;
    logic [7:0] mux_i0, mux_i1;
    logic       s0_0, s1_0, s2_0, s0_1, s1_1, s2_1;
    logic       y0, y1;
    logic       sout0, sout1, valid0, valid1, first0, first1, last0, last1, busy0, busy1;

    int unsigned checks;
    int unsigned passes;

    logic [2:0] exp_q0[$];
    logic [2:0] exp_q1[$];

    logic       stall_armed;
    logic [6:0] snap0, snap1;
    logic       rand_ready;

    // Behavioural 8:1 muxes closing the loop around each instance.
    assign y0 = mux_i0[{s2_0, s1_0, s0_0}];
    assign y1 = mux_i1[{s2_1, s1_1, s0_1}];

    mux_scan_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready0),
        .mux_i(mux_i0), .s0(s0_0), .s1(s1_0), .s2(s2_0), .mux_y(y0),
        .sout(sout0), .sout_valid(valid0), .sout_ready(sout_ready),
        .sout_first(first0), .sout_last(last0), .busy(busy0)
    );

    mux_scan_serializer #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready1),
        .mux_i(mux_i1), .s0(s0_1), .s1(s1_1), .s2(s2_1), .mux_y(y1),
        .sout(sout1), .sout_valid(valid1), .sout_ready(sout_ready),
        .sout_first(first1), .sout_last(last1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Monitor / scoreboard: consumption and acceptance both resolve on the next rising edge.
    always @(negedge clk) begin
        logic [2:0] e;
        if (rst) begin
            stall_armed = 1'b0;
        end else begin
            if (valid0 && sout_ready) begin
                if (exp_q0.size() == 0) begin
                    checks++;
                    $display("FAIL lsb_unexpected_bit: got %b expected none", {sout0, first0, last0});
                end else begin
                    e = exp_q0.pop_front();
                    check("lsb_bit_first_last", {sout0, first0, last0}, e);
                end
            end
            if (valid1 && sout_ready) begin
                if (exp_q1.size() == 0) begin
                    checks++;
                    $display("FAIL msb_unexpected_bit: got %b expected none", {sout1, first1, last1});
                end else begin
                    e = exp_q1.pop_front();
                    check("msb_bit_first_last", {sout1, first1, last1}, e);
                end
            end
            if (stall_armed) begin
                check("stall_hold_lsb", {sout0, valid0, first0, last0, s2_0, s1_0, s0_0}, snap0);
                check("stall_hold_msb", {sout1, valid1, first1, last1, s2_1, s1_1, s0_1}, snap1);
            end
            stall_armed = valid0 && !sout_ready;
            snap0 = {sout0, valid0, first0, last0, s2_0, s1_0, s0_0};
            snap1 = {sout1, valid1, first1, last1, s2_1, s1_1, s0_1};
            if (din_valid && din_ready0)
                for (int k = 0; k < 8; k++) exp_q0.push_back({din[k], k == 0, k == 7});
            if (din_valid && din_ready1)
                for (int k = 0; k < 8; k++) exp_q1.push_back({din[7-k], k == 0, k == 7});
        end
    end

    // Random back-pressure, applied away from the edges the main driver uses.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) sout_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Offers a word from posedge+1 until accepted; returns negedges waited for din_ready.
    task automatic send_word(input logic [7:0] w, output int waits);
        din       = w;
        din_valid = 1'b1;
        waits     = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!din_ready0 && waits < 100);
        if (!din_ready0) begin
            checks++;
            $display("FAIL accept_timeout: got din_ready 0 expected 1 for word %0h", w);
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_remaining", exp_q0.size() + exp_q1.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sout"}, {sout0, sout1}, 2'b00);
        check({tag, "_valid"}, {valid0, valid1}, 2'b00);
        check({tag, "_first_last"}, {first0, last0, first1, last1}, 4'b0000);
        check({tag, "_busy"}, {busy0, busy1}, 2'b00);
        check({tag, "_din_ready"}, {din_ready0, din_ready1}, 2'b00);
        check({tag, "_mux_i"}, {mux_i0, mux_i1}, 16'h0000);
        check({tag, "_sel_lsb"}, {s2_0, s1_0, s0_0}, 3'd0);
        check({tag, "_sel_msb"}, {s2_1, s1_1, s0_1}, 3'd7);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int n;
        checks      = 0;
        passes      = 0;
        stall_armed = 1'b0;
        rand_ready  = 1'b0;
        rst         = 1'b1;
        din         = 8'h00;
        din_valid   = 1'b0;
        sout_ready  = 1'b1;
        #1 din_valid = 1'b1;
        #1 check_reset_outputs("reset");
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single word, both scan orders.
        send_word(8'hB4, w);
        check("first_sel_lsb", {s2_0, s1_0, s0_0}, 3'd0);
        check("first_sel_msb", {s2_1, s1_1, s0_1}, 3'd7);
        check("busy_after_accept", {busy0, busy1}, 2'b11);
        check("hold_b4", mux_i0, 8'hB4);
        wait_drain();
        @(posedge clk);
        #1;
        check("idle_after_word", {busy0, valid0, busy1, valid1}, 4'b0000);

        // Back-to-back words with din_valid held.
        send_word(8'hFF, w);
        send_word(8'h00, w);
        check("b2b_ready_wait", w, 8);
        n = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (valid0 && valid1) n++;
        end
        check("b2b_contiguous", n, 9);
        wait_drain();

        // Back-pressure after bit 2.
        send_word(8'h5A, w);
        repeat (3) @(posedge clk);
        #1 sout_ready = 1'b0;
        repeat (3) @(posedge clk);
        check("stall_sel_lsb", {s2_0, s1_0, s0_0}, 3'd3);
        check("stall_sel_msb", {s2_1, s1_1, s0_1}, 3'd4);
        #1 sout_ready = 1'b1;
        wait_drain();

        // Asynchronous reset mid-word after bit 4.
        send_word(8'($urandom), w);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        #1 check_reset_outputs("midword_reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        send_word(8'h81, w);
        wait_drain();

        // din_valid toggling while busy must not capture anything.
        send_word(8'h3C, w);
        for (int i = 0; i < 6; i++) begin
            din       = 8'($urandom);
            din_valid = i[0];
            #1;
            check("busy_din_ready_low", {din_ready0, din_ready1}, 2'b00);
            check("busy_hold_kept", {mux_i0, mux_i1}, 16'h3C3C);
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        wait_drain();

        // Random words under random back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send_word(8'($urandom), w);
        end
        rand_ready = 1'b0;
        sout_ready = 1'b1;
        wait_drain();
        @(posedge clk);
        #1;
        check("final_idle", {busy0, valid0, busy1, valid1}, 4'b0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
